// File: rtl/pwr_gate_seq.sv
// Power-gating sequencer for one domain: orders clock gate, isolation, reset and
// power switch, waiting on the switch cell's delayed acknowledge in both directions.
module pwr_gate_seq #(
    parameter int ACK_TIMEOUT = 64,
    parameter int ISO_DELAY   = 2,
    parameter int RST_DELAY   = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwr_off_req_i,
    input  logic switch_ack_ni,
    input  logic err_clear_i,
    output logic switch_n_o,
    output logic iso_n_o,
    output logic rst_n_o,
    output logic clkgate_en_no,
    output logic domain_on_o,
    output logic busy_o,
    output logic timeout_err_o
);

    localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int DLY_MAX = (ISO_DELAY > RST_DELAY) ? ISO_DELAY : RST_DELAY;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    typedef enum logic [3:0] {
        ST_ON, ST_OFF_CG, ST_OFF_ISO, ST_OFF_RST, ST_OFF_SW,
        ST_OFF, ST_ON_SW, ST_ON_ISO, ST_ON_RST, ST_ON_CG
    } state_t;

    state_t             state_q, state_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic               ack_meta_q, ack_sync_q;
    logic               err_set;
    logic               switch_n_q, iso_n_q, rst_n_q, clkgate_en_q, domain_on_q, busy_q, err_q;
    logic               switch_n_d, iso_n_d, rst_n_d, clkgate_en_d, domain_on_d, busy_d, err_d;

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_ON;
            ack_cnt_q    <= '0;
            dly_cnt_q    <= '0;
            ack_meta_q   <= 1'b0;
            ack_sync_q   <= 1'b0;
            switch_n_q   <= 1'b0;
            iso_n_q      <= 1'b1;
            rst_n_q      <= 1'b1;
            clkgate_en_q <= 1'b0;
            domain_on_q  <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_cnt_q    <= ack_cnt_d;
            dly_cnt_q    <= dly_cnt_d;
            ack_meta_q   <= switch_ack_ni;
            ack_sync_q   <= ack_meta_q;
            switch_n_q   <= switch_n_d;
            iso_n_q      <= iso_n_d;
            rst_n_q      <= rst_n_d;
            clkgate_en_q <= clkgate_en_d;
            domain_on_q  <= domain_on_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        dly_cnt_d = dly_cnt_q;
        err_set   = 1'b0;
        unique case (state_q)
            ST_ON:      if (pwr_off_req_i) state_d = ST_OFF_CG;
            ST_OFF_CG: begin
                state_d   = ST_OFF_ISO;
                dly_cnt_d = '0;
            end
            ST_OFF_ISO: begin
                if (dly_cnt_q == DLY_W'(ISO_DELAY - 1)) begin
                    state_d   = ST_OFF_RST;
                    dly_cnt_d = '0;
                end else dly_cnt_d = dly_cnt_q + 1'b1;
            end
            ST_OFF_RST: begin
                if (dly_cnt_q == DLY_W'(RST_DELAY - 1)) begin
                    state_d   = ST_OFF_SW;
                    ack_cnt_d = '0;
                end else dly_cnt_d = dly_cnt_q + 1'b1;
            end
            // A missing ack is treated as arrived once the timeout expires.
            ST_OFF_SW: begin
                if (ack_sync_q) state_d = ST_OFF;
                else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_OFF;
                    err_set = 1'b1;
                end else ack_cnt_d = ack_cnt_q + 1'b1;
            end
            ST_OFF: begin
                if (!pwr_off_req_i) begin
                    state_d   = ST_ON_SW;
                    ack_cnt_d = '0;
                end
            end
            ST_ON_SW: begin
                if (!ack_sync_q) begin
                    state_d   = ST_ON_ISO;
                    dly_cnt_d = '0;
                end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_d   = ST_ON_ISO;
                    dly_cnt_d = '0;
                    err_set   = 1'b1;
                end else ack_cnt_d = ack_cnt_q + 1'b1;
            end
            ST_ON_ISO: begin
                if (dly_cnt_q == DLY_W'(ISO_DELAY - 1)) begin
                    state_d   = ST_ON_RST;
                    dly_cnt_d = '0;
                end else dly_cnt_d = dly_cnt_q + 1'b1;
            end
            ST_ON_RST: begin
                if (dly_cnt_q == DLY_W'(RST_DELAY - 1)) state_d = ST_ON_CG;
                else dly_cnt_d = dly_cnt_q + 1'b1;
            end
            ST_ON_CG:   state_d = ST_ON;
            default:    state_d = ST_ON;
        endcase
    end

    always_comb begin
        switch_n_d   = state_d inside {ST_OFF_SW, ST_OFF};
        iso_n_d      = state_d inside {ST_ON, ST_OFF_CG, ST_ON_ISO, ST_ON_RST, ST_ON_CG};
        rst_n_d      = state_d inside {ST_ON, ST_OFF_CG, ST_OFF_ISO, ST_ON_RST, ST_ON_CG};
        clkgate_en_d = !(state_d inside {ST_ON, ST_ON_CG});
        domain_on_d  = (state_d == ST_ON);
        busy_d       = !(state_d inside {ST_ON, ST_OFF});
        err_d        = err_set | (err_q & ~err_clear_i);
    end

    assign switch_n_o    = switch_n_q;
    assign iso_n_o       = iso_n_q;
    assign rst_n_o       = rst_n_q;
    assign clkgate_en_no = clkgate_en_q;
    assign domain_on_o   = domain_on_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_pwr_gate_seq.sv
// Bench for pwr_gate_seq: a switch-cell model returns ack after a chosen latency and
// every output change is matched against a timeline predicted from the sequencing rules.
`timescale 1ns/1ps
module tb_pwr_gate_seq;
    localparam int ACK_TIMEOUT = 64;
    localparam int ISO_DELAY   = 2;
    localparam int RST_DELAY   = 2;
    localparam int SW = 6, ISO = 5, RST = 4, CG = 3, DON = 2, BUSY = 1, ERR = 0;
    // {switch_n, iso_n, rst_n, clkgate_en_n, domain_on, busy, timeout_err}
    localparam logic [6:0] RESET_VEC = 7'b0110100;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic rst, req, ack_n, err_clr;
    logic switch_n_o, iso_n_o, rst_n_o, clkgate_en_no, domain_on_o, busy_o, timeout_err_o;

    int         cyc = 0;
    int         lat = 5;
    bit         tied = 1'b0;
    bit         glitch = 1'b0;
    bit         mon_en = 1'b0;
    bit         hist[int];
    ev_t        sb_q[$];
    logic [6:0] model_vec;
    int         cut_cyc;
    int         n_checks = 0;
    int         n_pass = 0;

    pwr_gate_seq #(.ACK_TIMEOUT(ACK_TIMEOUT), .ISO_DELAY(ISO_DELAY), .RST_DELAY(RST_DELAY)) dut (
        .clk_i(clk), .rst_i(rst), .pwr_off_req_i(req), .switch_ack_ni(ack_n),
        .err_clear_i(err_clr), .switch_n_o(switch_n_o), .iso_n_o(iso_n_o),
        .rst_n_o(rst_n_o), .clkgate_en_no(clkgate_en_no), .domain_on_o(domain_on_o),
        .busy_o(busy_o), .timeout_err_o(timeout_err_o)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dut_vec();
        return {switch_n_o, iso_n_o, rst_n_o, clkgate_en_no, domain_on_o, busy_o, timeout_err_o};
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, got, exp);
    endtask

    // Switch cell: ack_n follows switch_n with 'lat' cycles of delay (or is tied low).
    initial begin
        bit nom;
        ack_n = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            hist[cyc] = switch_n_o;
            if (tied) nom = 1'b0;
            else if (hist.exists(cyc - (lat - 1))) nom = hist[cyc - (lat - 1)];
            else nom = 1'b0;
            ack_n = glitch ? ~nom : nom;
        end
    end

    // Monitor: every change of the output vector must match the next predicted event.
    initial begin
        logic [6:0] prev_vec, cur_vec;
        ev_t        e;
        prev_vec = RESET_VEC;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur_vec = dut_vec();
                if (cur_vec !== prev_vec) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_change cyc=%0d got=%b expected unchanged %b", cyc, cur_vec, prev_vec);
                    end else begin
                        e = sb_q.pop_front();
                        check("event_cycle", cyc, cyc, e.cyc);
                        check("event_outputs", cyc, {25'd0, cur_vec}, {25'd0, e.vec});
                    end
                    prev_vec = cur_vec;
                end
            end
        end
    end

    task automatic add_ev(input int c, input int pos, input logic v);
        logic [6:0] old;
        ev_t        e;
        old = model_vec;
        model_vec[pos] = v;
        if (old == model_vec || c >= cut_cyc) return;
        if (sb_q.size() > 0 && sb_q[sb_q.size()-1].cyc == c) sb_q[sb_q.size()-1].vec = model_vec;
        else begin
            e.cyc = c;
            e.vec = model_vec;
            sb_q.push_back(e);
        end
    endtask

    // Cycles spent waiting for ack: it reaches the FSM lat+2 cycles after the switch moves.
    function automatic int ack_wait(input bit to_off);
        if (tied) return to_off ? ACK_TIMEOUT : 1;
        return (lat + 2 <= ACK_TIMEOUT) ? lat + 2 : ACK_TIMEOUT;
    endfunction

    function automatic bit ack_late(input bit to_off);
        if (tied) return to_off;
        return lat + 2 > ACK_TIMEOUT;
    endfunction

    task automatic plan_off(input int r, output int f);
        int s;
        add_ev(r, CG, 1'b1); add_ev(r, DON, 1'b0); add_ev(r, BUSY, 1'b1);
        add_ev(r + 1, ISO, 1'b0);
        add_ev(r + 1 + ISO_DELAY, RST, 1'b0);
        s = r + 1 + ISO_DELAY + RST_DELAY;
        add_ev(s, SW, 1'b1);
        f = s + ack_wait(1'b1);
        add_ev(f, BUSY, 1'b0);
        if (ack_late(1'b1)) add_ev(f, ERR, 1'b1);
    endtask

    task automatic plan_on(input int r, output int f);
        int k, c;
        add_ev(r, SW, 1'b0); add_ev(r, BUSY, 1'b1);
        k = ack_wait(1'b0);
        add_ev(r + k, ISO, 1'b1);
        if (ack_late(1'b0)) add_ev(r + k, ERR, 1'b1);
        add_ev(r + k + ISO_DELAY, RST, 1'b1);
        c = r + k + ISO_DELAY + RST_DELAY;
        add_ev(c, CG, 1'b0);
        f = c + 1;
        add_ev(f, DON, 1'b1); add_ev(f, BUSY, 1'b0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic request(input bit off, output int r, output int f);
        req = off;
        r = cyc + 1;
        if (off) plan_off(r, f);
        else plan_on(r, f);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        add_ev(cyc + 1, ERR, 1'b0);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int  r, f, f2, c;
        bit  is_off;
        ev_t e;
        rst = 1'b1; req = 1'b0; err_clr = 1'b0;
        cut_cyc = 1 << 30;
        model_vec = RESET_VEC;
        repeat (3) @(negedge clk);
        check("reset_outputs", cyc, {25'd0, dut_vec()}, {25'd0, RESET_VEC});
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Off then on with ack latency 15.
        lat = 15;
        request(1'b1, r, f); wait_to(f + 80);
        request(1'b0, r, f); wait_to(f + 80);

        // Ack tied low: off times out, flag is sticky until cleared; on sees ack already matching.
        tied = 1'b1;
        request(1'b1, r, f); wait_to(f + 80);
        clear_err();
        request(1'b0, r, f); wait_to(f + 80);
        tied = 1'b0;

        // Request drops during OFF_ISO: off completes, then on starts on the next edge.
        lat = 6;
        request(1'b1, r, f);
        wait_to(r + 1);
        req = 1'b0;
        plan_on(f + 1, f2);
        wait_to(f2 + 80);

        // Clear pulse coinciding with a timeout: the set wins.
        lat = 70;
        request(1'b1, r, f);
        wait_to(f - 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        wait_to(f + 80);
        clear_err();
        lat = 8;
        request(1'b0, r, f); wait_to(f + 80);

        // Ack glitches in stable ON and OFF are ignored.
        glitch = 1'b1; repeat (4) @(negedge clk); glitch = 1'b0; repeat (10) @(negedge clk);
        request(1'b1, r, f); wait_to(f + 80);
        glitch = 1'b1; repeat (4) @(negedge clk); glitch = 1'b0; repeat (10) @(negedge clk);
        request(1'b0, r, f); wait_to(f + 80);

        // Asynchronous reset while waiting in OFF_SW.
        lat = 10;
        cut_cyc = cyc + 1 + 1 + ISO_DELAY + RST_DELAY + 3;
        c = cut_cyc;
        request(1'b1, r, f);
        wait_to(c - 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        cut_cyc = 1 << 30;
        model_vec = RESET_VEC;
        e.cyc = c;
        e.vec = RESET_VEC;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        rst = 1'b0;
        wait_to(c + 80);

        // Random traffic, occasionally with a late ack that forces a timeout.
        is_off = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(63, 72)) : int'($urandom_range(1, 20));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            is_off = ~is_off;
            request(is_off, r, f);
            wait_to(f + 80);
            if ($urandom_range(0, 2) == 0) clear_err();
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", cyc, sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
